// File: rtl/srambank_array.sv
// Multi-port, multi-bank word SRAM. Each bank is single-ported, so each bank runs
// its own round-robin arbiter between the ports that target it. Reads return one cycle later.
module srambank_array #(
  parameter int ADDRESS   = 9,
  parameter int DATA      = 18,
  parameter int BANK_BITS = 2,
  parameter int NPORTS    = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NPORTS-1:0]                i_req_valid,
  input  logic [NPORTS-1:0]                i_req_we,
  input  logic [NPORTS*(ADDRESS+BANK_BITS)-1:0] i_req_addr,
  input  logic [NPORTS*DATA-1:0]           i_req_wdata,
  output logic [NPORTS-1:0]                o_req_ready,
  output logic [NPORTS-1:0]                o_rsp_valid,
  output logic [NPORTS*DATA-1:0]           o_rsp_data
);

  localparam int AW     = ADDRESS + BANK_BITS;
  localparam int NBANKS = 1 << BANK_BITS;
  localparam int DEPTH  = 1 << ADDRESS;
  localparam int PW     = $clog2(NPORTS);

  // Handshake: a request is accepted in a cycle where valid and ready are both 1.
  // Ungranted ports hold their request; responses carry no backpressure.

  logic [DATA-1:0]    mem_q [NBANKS][DEPTH];
  logic [PW-1:0]      ptr_q [NBANKS];
  logic [PW-1:0]      ptr_d [NBANKS];
  logic [NBANKS-1:0]  bank_gnt;
  logic [PW-1:0]      bank_sel   [NBANKS];
  logic [NBANKS-1:0]  bank_we;
  logic [ADDRESS-1:0] bank_idx   [NBANKS];
  logic [DATA-1:0]    bank_wdata [NBANKS];
  logic [NPORTS-1:0]  ready;
  logic [NPORTS-1:0]  rsp_valid_q;
  logic [NPORTS*DATA-1:0] rsp_data_q;

  // Per-bank arbitration: first valid requester at or after the bank's pointer.
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      logic found;
      found         = 1'b0;
      bank_gnt[b]   = 1'b0;
      bank_sel[b]   = '0;
      bank_we[b]    = 1'b0;
      bank_idx[b]   = '0;
      bank_wdata[b] = '0;
      for (int k = 0; k < NPORTS; k++) begin
        int p;
        p = (int'(ptr_q[b]) + k) % NPORTS;
        if (!found && i_rst_n && i_req_valid[p] &&
            (int'(i_req_addr[p*AW +: BANK_BITS]) == b)) begin
          found         = 1'b1;
          bank_gnt[b]   = 1'b1;
          bank_sel[b]   = PW'(p);
          bank_we[b]    = i_req_we[p];
          bank_idx[b]   = i_req_addr[p*AW+BANK_BITS +: ADDRESS];
          bank_wdata[b] = i_req_wdata[p*DATA +: DATA];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      logic [BANK_BITS-1:0] pb;
      pb       = i_req_addr[p*AW +: BANK_BITS];
      ready[p] = i_rst_n && i_req_valid[p] && bank_gnt[pb] && (bank_sel[pb] == PW'(p));
    end
  end

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      ptr_d[b] = ptr_q[b];
      if (bank_gnt[b]) begin
        ptr_d[b] = (bank_sel[b] == PW'(NPORTS-1)) ? '0 : bank_sel[b] + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NBANKS; b++) ptr_q[b] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) ptr_q[b] <= ptr_d[b];
      for (int p = 0; p < NPORTS; p++) begin
        rsp_valid_q[p] <= ready[p] && !i_req_we[p];
        if (ready[p] && !i_req_we[p]) begin
          rsp_data_q[p*DATA +: DATA] <=
            mem_q[i_req_addr[p*AW +: BANK_BITS]][i_req_addr[p*AW+BANK_BITS +: ADDRESS]];
        end
      end
    end
  end

  // Storage is never reset; bank_gnt is already gated by reset so no write leaks in.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (bank_gnt[b] && bank_we[b]) begin
        mem_q[b][bank_idx[b]] <= bank_wdata[b];
      end
    end
  end

  assign o_req_ready = ready;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_srambank_array.sv
// Bench for srambank_array: directed scenarios plus random traffic checked
// against a flat-memory / round-robin reference model.
module tb_srambank_array;

  localparam int A  = 9;
  localparam int D  = 18;
  localparam int BB = 2;
  localparam int NP = 2;
  localparam int AW = A + BB;
  localparam int NB = 1 << BB;
  localparam int NW = 1 << AW;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     valid;
  logic [NP-1:0]     we;
  logic [AW-1:0]     addr  [NP];
  logic [D-1:0]      wdata [NP];
  logic [NP*AW-1:0]  addr_bus;
  logic [NP*D-1:0]   wdata_bus;
  logic [NP-1:0]     o_req_ready;
  logic [NP-1:0]     o_rsp_valid;
  logic [NP*D-1:0]   o_rsp_data;

  // reference model state
  logic [D-1:0]      mem_m [NW];
  int                rr [NB];
  logic [NP-1:0]     exp_rv;
  logic [D-1:0]      exp_rd [NP];
  logic [NP-1:0]     last_ready;
  logic [D-1:0]      exp_q [$];

  int n_checks;
  int n_errors;

  srambank_array #(.ADDRESS(A), .DATA(D), .BANK_BITS(BB), .NPORTS(NP)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .i_req_we    (we),
    .i_req_addr  (addr_bus),
    .i_req_wdata (wdata_bus),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      addr_bus[p*AW +: AW] = addr[p];
      wdata_bus[p*D +: D]  = wdata[p];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner per bank = valid requester with smallest round-robin distance from the pointer.
  task automatic model_grants(output logic [NP-1:0] g);
    g = '0;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        int best;
        int bestd;
        best  = -1;
        bestd = NP;
        for (int p = 0; p < NP; p++) begin
          if (valid[p] && (int'(addr[p]) % NB == b)) begin
            int d;
            d = (p - rr[b] + NP) % NP;
            if (d < bestd) begin
              bestd = d;
              best  = p;
            end
          end
        end
        if (best >= 0) g[best] = 1'b1;
      end
    end
  endtask

  task automatic model_commit(input logic [NP-1:0] g);
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) rr[b] = 0;
      exp_rv = '0;
      for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        exp_rv[p] = g[p] && !we[p];
        if (g[p] && !we[p]) exp_rd[p] = mem_m[addr[p]];
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p]) begin
          if (we[p]) mem_m[addr[p]] = wdata[p];
          rr[int'(addr[p]) % NB] = (p + 1) % NP;
        end
      end
    end
  endtask

  // driver: called just after a falling edge with inputs already set
  task automatic do_cycle();
    logic [NP-1:0] g;
    #1;
    model_grants(g);
    last_ready = o_req_ready;
    check("ready", o_req_ready, g);
    model_commit(g);
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rsp_valid%0d", p), o_rsp_valid[p], exp_rv[p]);
      check($sformatf("rsp_data%0d", p), o_rsp_data[p*D +: D], exp_rd[p]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    do_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] pat [4];
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    valid = '0;
    we    = '0;
    for (int p = 0; p < NP; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
    end
    for (int b = 0; b < NB; b++) rr[b] = 0;
    exp_rv = '0;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    last_ready = '0;

    @(negedge clk);
    do_cycle();
    do_cycle();
    valid = 2'b11;
    do_cycle();
    check("reset_ready", last_ready, 0);
    check("reset_rsp_valid", o_rsp_valid, 0);
    check("reset_rsp_data", o_rsp_data, 0);
    valid = '0;
    rst_n = 1'b1;

    // fill all words with address-as-data, then read back in order
    for (int i = 0; i < NW; i++) begin
      valid = 2'b01; we = 2'b01;
      addr[0] = AW'(i); wdata[0] = D'(i);
      do_cycle();
      check("fill_ready", last_ready[0], 1'b1);
    end
    we = '0;
    for (int i = 0; i < NW; i++) begin
      addr[0] = AW'(i);
      exp_q.push_back(D'(i));
      do_cycle();
      check("rb_valid", o_rsp_valid[0], 1'b1);
      check("rb_data", o_rsp_data[D-1:0], exp_q.pop_front());
    end
    valid = '0;
    do_cycle();

    // write on port0, read same address on port1 next cycle
    valid = 2'b01; we = 2'b01; addr[0] = 11'h004; wdata[0] = 18'h2AAAA;
    do_cycle();
    valid = 2'b10; we = 2'b00; addr[1] = 11'h004;
    do_cycle();
    check("wr_rd_valid", o_rsp_valid, 2'b10);
    check("wr_rd_data", o_rsp_data[2*D-1:D], 18'h2AAAA);

    // different banks both granted
    valid = 2'b11; we = 2'b00; addr[0] = 11'h001; addr[1] = 11'h002;
    do_cycle();
    check("diff_bank_ready", last_ready, 2'b11);
    check("diff_bank_rsp", o_rsp_valid, 2'b11);
    check("diff_bank_d0", o_rsp_data[D-1:0], 18'h001);
    check("diff_bank_d1", o_rsp_data[2*D-1:D], 18'h002);

    // contention on bank3 alternates after reset
    do_reset();
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    valid = 2'b11; we = 2'b00; addr[0] = 11'h003; addr[1] = 11'h007;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check("rr_grant", last_ready, pat[i]);
      check("rr_rsp", o_rsp_valid, pat[i]);
    end

    // lone port1 at pointer 0, then pointer wraps back to 0
    do_reset();
    valid = 2'b10; we = 2'b00; addr[1] = 11'h000;
    do_cycle();
    check("lone_p1", last_ready, 2'b10);
    valid = 2'b11; addr[0] = 11'h008;
    do_cycle();
    check("ptr_wrap", last_ready, 2'b01);

    // read then reset: response cleared, no write during reset
    valid = 2'b01; we = 2'b00; addr[0] = 11'h009;
    do_cycle();
    check("pre_rst_ready", last_ready, 2'b01);
    check("pre_rst_rsp", o_rsp_valid, 2'b01);
    rst_n = 1'b0;
    valid = 2'b11; we = 2'b10; addr[1] = 11'h005; wdata[1] = 18'h3FFFF;
    do_cycle();
    check("in_rst_ready", last_ready, 0);
    check("post_rst_valid", o_rsp_valid, 0);
    check("post_rst_data", o_rsp_data, 0);
    rst_n = 1'b1;
    valid = 2'b01; we = 2'b00; addr[0] = 11'h005;
    do_cycle();
    check("no_rst_write", o_rsp_data[D-1:0], 18'h005);

    // random traffic; ungranted requests are held
    valid = '0;
    last_ready = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < NP; p++) begin
        if (!(valid[p] && !last_ready[p])) begin
          valid[p] = ($urandom_range(0, 3) != 0);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = AW'($urandom_range(0, NW-1));
          wdata[p] = D'($urandom);
        end
      end
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
